// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues fetch requests, holds the fetched word until
// execute consumes it, computes the next PC, and stops on halt or ack timeout.
module instr_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_wre,
  input  logic        pc_src,
  input  logic [31:0] ext_imm,
  input  logic        exec_done,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic        halted,
  output logic        fetch_err
);

  localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(ACK_TIMEOUT);
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [1:0] {FETCH, HOLD, HALT} state_t;

  state_t        state, stateNext;
  logic [CW-1:0] waitCnt, waitCntNext, waitCntInc;
  logic          loadInstr, loadPc, timeout;
  logic [31:0]   pcNext;

  // Sequential and branch targets; wraps modulo 2^32 naturally.
  assign pcNext = pc + 32'd4 + (pc_src ? (ext_imm << 2) : 32'd0);
  assign waitCntInc = waitCnt + 1'b1;

  assign imem_addr   = pc;
  assign instr_valid = (state == HOLD);
  assign halted      = (state == HALT);
  assign op          = instr[31:26];
  assign rs          = instr[25:21];
  assign rt          = instr[20:16];
  assign rd          = instr[15:11];
  assign imm16       = instr[15:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= stateNext;
  end

  // Next-state decode plus datapath load strobes.
  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    loadInstr   = 1'b0;
    loadPc      = 1'b0;
    timeout     = 1'b0;
    case (state)
      FETCH: begin
        // An ack is accepted in FETCH even in the first post-reset cycle
        // before the request is visible; the wait count only runs while the
        // request is actually raised.
        if (imem_ack) begin
          loadInstr   = 1'b1;
          waitCntNext = '0;
          stateNext   = HOLD;
        end else if (imem_req) begin
          if (waitCntInc == TMO) begin
            timeout     = 1'b1;
            waitCntNext = '0;
            stateNext   = HALT;
          end else begin
            waitCntNext = waitCntInc;
          end
        end
      end
      HOLD: begin
        if (exec_done) begin
          if (op != OP_HALT && pc_wre) begin
            loadPc    = 1'b1;
            stateNext = FETCH;
          end else begin
            stateNext = HALT;
          end
        end
      end
      HALT:    stateNext = HALT;
      default: stateNext = FETCH;
    endcase
  end

  // Datapath registers; the request is registered so it rises one edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      instr     <= '0;
      waitCnt   <= '0;
      imem_req  <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      waitCnt  <= waitCntNext;
      imem_req <= (stateNext == FETCH);
      if (loadInstr) instr <= imem_rdata;
      if (loadPc)    pc <= pcNext;
      if (timeout)   fetch_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, branch, wrap, halt,
// timeout and asynchronous reset behaviour.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_wre, pc_src, exec_done, imem_ack;
  logic [31:0] ext_imm, imem_rdata;
  logic        imem_req, instr_valid, halted, fetch_err;
  logic [31:0] imem_addr, instr, pc;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;

  int checks = 0;
  int errors = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .pc_wre(pc_wre), .pc_src(pc_src),
    .ext_imm(ext_imm), .exec_done(exec_done), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .op(op), .rs(rs), .rt(rt), .rd(rd), .imm16(imm16),
    .instr_valid(instr_valid), .pc(pc), .halted(halted), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic reqSeen;
    int   reqCycles;

    rst_n = 1'b0; pc_wre = 1'b0; pc_src = 1'b0; exec_done = 1'b0;
    imem_ack = 1'b0; ext_imm = '0; imem_rdata = '0;
    #2;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("req_after_rst", {31'd0, imem_req}, 32'd1);
    chk("addr0", imem_addr, 32'h0);

    // exec_done during FETCH must not move the PC
    exec_done = 1'b1; pc_src = 1'b1; pc_wre = 1'b1; ext_imm = 32'd5;
    tick(); tick();
    chk("fetch_ignores_exec_pc", pc, 32'h0);
    chk("fetch_no_valid", {31'd0, instr_valid}, 32'd0);
    chk("fetch_req_held", {31'd0, imem_req}, 32'd1);

    exec_done = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_0000;
    tick();
    chk("hold_valid", {31'd0, instr_valid}, 32'd1);
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    chk("hold_instr0", instr, 32'h0);

    imem_ack = 1'b0; exec_done = 1'b1; pc_wre = 1'b1; pc_src = 1'b0;
    tick();
    chk("seq_pc4", pc, 32'h4);
    chk("seq_addr4", imem_addr, 32'h4);
    chk("seq_req4", {31'd0, imem_req}, 32'd1);
    chk("valid_one_cycle", {31'd0, instr_valid}, 32'd0);
    exec_done = 1'b0;

    imem_ack = 1'b1; imem_rdata = 32'h0;
    tick();
    imem_ack = 1'b0; exec_done = 1'b1; pc_src = 1'b0;
    tick();
    chk("seq_pc8", pc, 32'h8);
    exec_done = 1'b0;

    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    chk("dec_instr", instr, 32'h1234_5678);
    chk("dec_op", {26'd0, op}, 32'd4);
    chk("dec_rs", {27'd0, rs}, 32'd17);
    chk("dec_rt", {27'd0, rt}, 32'd20);
    chk("dec_rd", {27'd0, rd}, 32'd10);
    chk("dec_imm", {16'd0, imm16}, 32'h5678);

    // ack during HOLD must be ignored
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("hold_ack_instr", instr, 32'h1234_5678);
    chk("hold_ack_valid", {31'd0, instr_valid}, 32'd1);
    chk("hold_ack_pc", pc, 32'h8);

    imem_ack = 1'b0; exec_done = 1'b1; pc_src = 1'b1; ext_imm = 32'hFFFF_FFFE;
    tick();
    chk("branch_back_pc", pc, 32'h4);
    exec_done = 1'b0; pc_src = 1'b0;

    imem_ack = 1'b1; imem_rdata = 32'h0;
    tick();
    imem_ack = 1'b0; exec_done = 1'b1; pc_src = 1'b1; ext_imm = 32'hFFFF_FFFD;
    tick();
    chk("branch_to_top", pc, 32'hFFFF_FFFC);
    exec_done = 1'b0; pc_src = 1'b0;

    imem_ack = 1'b1; imem_rdata = 32'h0;
    tick();
    imem_ack = 1'b0; exec_done = 1'b1;
    tick();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    exec_done = 1'b0;

    imem_ack = 1'b1; imem_rdata = 32'h0;
    tick();
    imem_ack = 1'b0; exec_done = 1'b1;
    tick();
    exec_done = 1'b0;

    // halt opcode at pc=4
    imem_ack = 1'b1; imem_rdata = 32'hFC00_0000;
    tick();
    chk("halt_op", {26'd0, op}, 32'h3F);
    imem_ack = 1'b0; exec_done = 1'b1; pc_wre = 1'b1; pc_src = 1'b1; ext_imm = 32'd8;
    tick();
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_pc", pc, 32'h4);
    reqSeen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      imem_ack = (i % 2 == 0); imem_rdata = 32'h1111_1111;
      tick();
      reqSeen = reqSeen | imem_req | instr_valid | ~halted;
    end
    chk("halt_20cyc_quiet", {31'd0, reqSeen}, 32'd0);
    chk("halt_pc_stable", pc, 32'h4);
    chk("halt_instr_stable", instr, 32'hFC00_0000);
    imem_ack = 1'b0; exec_done = 1'b0; pc_src = 1'b0;

    // halt via pc_wre=0
    rst_n = 1'b0;
    #1;
    chk("rst2_instr", instr, 32'h0);
    chk("rst2_halted", {31'd0, halted}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h0;
    tick();
    imem_ack = 1'b0; exec_done = 1'b1; pc_wre = 1'b0;
    tick();
    chk("wre0_halted", {31'd0, halted}, 32'd1);
    chk("wre0_pc", pc, 32'h0);
    exec_done = 1'b0; pc_wre = 1'b1;

    // ack timeout
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    reqCycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (halted) break;
      if (imem_req) reqCycles++;
      tick();
    end
    chk("tmo_req_cycles", reqCycles, 32'd15);
    chk("tmo_err", {31'd0, fetch_err}, 32'd1);
    chk("tmo_halted", {31'd0, halted}, 32'd1);
    chk("tmo_req_drop", {31'd0, imem_req}, 32'd0);

    // asynchronous reset mid-fetch
    rst_n = 1'b0;
    #1;
    chk("rst3_err_clear", {31'd0, fetch_err}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h0;
    tick();
    imem_ack = 1'b0; exec_done = 1'b1; pc_src = 1'b0;
    tick();
    exec_done = 1'b0;
    chk("pre_async_pc", pc, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", {31'd0, imem_req}, 32'd0);
    chk("async_pc", pc, 32'h0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_async_req", {31'd0, imem_req}, 32'd1);
    chk("post_async_addr", imem_addr, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h2108_0003;
    tick();
    chk("late_ack_instr", instr, 32'h2108_0003);
    chk("late_ack_valid", {31'd0, instr_valid}, 32'd1);
    imem_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
